// File: rtl/fc_act_collector.sv
// Serial-to-parallel activation collector around a combinational FC neuron.
// Holds x_out stable for a settle window, then captures z and hands it off over valid/ready.
module fc_act_collector #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned IN     = 128,
  parameter int unsigned SETTLE = 2,
  parameter int unsigned ZW     = WIDTH * 2 + $clog2(IN)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_last,
  output logic [IN-1:0][WIDTH-1:0]   x_out,
  input  logic [ZW-1:0]              z_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ZW-1:0]              out_data,
  output logic                       frame_err
);

  localparam int unsigned IW = (IN > 1) ? $clog2(IN) : 1;
  localparam logic [IW-1:0] LastIdx = IW'(IN - 1);
  localparam logic [3:0] SettleMax = 4'(SETTLE);

  typedef enum logic [1:0] {StFill, StSettle, StOut} state_e;

  state_e                     state_q, state_d;
  logic [IW-1:0]              idx_q, idx_d;
  logic [3:0]                 cnt_q, cnt_d;
  logic                       rdy_q, rdy_d;
  logic [IN-1:0][WIDTH-1:0]   x_d;
  logic                       out_valid_d;
  logic [ZW-1:0]              out_data_d;
  logic                       frame_err_d;
  logic                       accept;

  assign in_ready = rdy_q;
  assign accept   = in_valid & rdy_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    x_d         = x_out;
    out_valid_d = out_valid;
    out_data_d  = out_data;
    frame_err_d = 1'b0;

    unique case (state_q)
      StFill: begin
        if (accept) begin
          x_d[idx_q] = in_data;
          if (idx_q == LastIdx || in_last) begin
            state_d     = StSettle;
            idx_d       = '0;
            cnt_d       = '0;
            frame_err_d = (idx_q != LastIdx) || !in_last;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StSettle: begin
        // Window starts on the cycle after the last element lands, hence SETTLE+1 states.
        if (cnt_q == SettleMax) begin
          out_data_d  = z_in;
          out_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = StOut;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StOut: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          x_d         = '0;
          state_d     = StFill;
        end
      end
      default: state_d = StFill;
    endcase

    // Registered so in_ready stays low through reset and rises one cycle later.
    rdy_d = (state_d == StFill);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StFill;
      idx_q     <= '0;
      cnt_q     <= '0;
      rdy_q     <= 1'b0;
      x_out     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      rdy_q     <= rdy_d;
      x_out     <= x_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      frame_err <= frame_err_d;
    end
  end

endmodule
